input_conditioner: RTL and testbench

Parametrised successor to the flat user-input buffer. Takes WIDTH raw asynchronous inputs (buttons, switches, GPIO, SNES bits), synchronises them and applies per-bit polarity. Each bit is debounced on a shared prescaled sample tick, and sticky rising-edge ("press") flags are latched for the processor. Sits between board pins and the processor INPUT path; `buf_inputs` replaces the old registered concatenation.

---
 rtl/input_conditioner.sv | 64 ++++++
 tb/tb_input_conditioner.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise, polarity-correct, debounce and edge-flag raw board inputs
module input_conditioner #(
  parameter int WIDTH = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV = 1000,
  parameter int DB_SAMPLES = 4,
  parameter logic [WIDTH-1:0] INVERT_MASK = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_inputs,
  input  logic             clr_en,
  input  logic [WIDTH-1:0] clr_mask,
  output logic [WIDTH-1:0] buf_inputs,
  output logic [WIDTH-1:0] edge_flags,
  output logic             any_edge,
  output logic             sample_tick
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DB_SAMPLES) + 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_SAMPLES - 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [PW-1:0] pre_q, pre_d;
  logic tick_q, tick_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] buf_q, buf_d, flag_q, flag_d, pol;
  assign pol = sync_q[SYNC_STAGES-1] ^ INVERT_MASK;
  assign pre_d = (pre_q == PMAX) ? '0 : pre_q + 1'b1;
  assign tick_d = (pre_q == PMAX);
  // per-bit debounce: count mismatching ticks, toggle the level once DB_SAMPLES are seen in a row
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = !tick_q ? cnt_q[i] : (pol[i] == buf_q[i] || cnt_q[i] == CMAX) ? '0 : cnt_q[i] + 1'b1;
      buf_d[i] = buf_q[i] ^ (tick_q && pol[i] != buf_q[i] && cnt_q[i] == CMAX);
    end
  end
  // sticky rising-edge flags; a new rise on the same edge beats a clear
  assign flag_d = (flag_q & ~(clr_mask & {WIDTH{clr_en}})) | (buf_d & ~buf_q);
  // synchroniser chain, prescaler, debounce state and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
      buf_q  <= '0;
      flag_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_inputs};
      pre_q  <= pre_d;
      tick_q <= tick_d;
      cnt_q  <= cnt_d;
      buf_q  <= buf_d;
      flag_q <= flag_d;
    end
  end
  assign buf_inputs = buf_q;
  assign edge_flags = flag_q;
  assign any_edge = |flag_q;
  assign sample_tick = tick_q;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for input_conditioner across three parameter sets
module tb_input_conditioner;
  logic clk, rst_n, clr_en;
  logic [7:0] raw_a, raw_b, raw_c, clr_mask;
  logic [7:0] buf_a, flg_a, buf_b, flg_b, buf_c, flg_c;
  logic any_a, tick_a, any_b, tick_b, any_c, tick_c;
  int cyc = 0, n_chk = 0, n_fail = 0, rel = 0;
  typedef struct { int tag; int sel; logic [7:0] exp; string name; } exp_t;
  exp_t sb[$];

  input_conditioner #(.WIDTH(8), .SYNC_STAGES(2), .TICK_DIV(1), .DB_SAMPLES(3), .INVERT_MASK(8'h0F)) dut_a (
    .clk(clk), .rst_n(rst_n), .raw_inputs(raw_a), .clr_en(clr_en), .clr_mask(clr_mask),
    .buf_inputs(buf_a), .edge_flags(flg_a), .any_edge(any_a), .sample_tick(tick_a));
  input_conditioner #(.WIDTH(8), .SYNC_STAGES(2), .TICK_DIV(4), .DB_SAMPLES(2), .INVERT_MASK(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .raw_inputs(raw_b), .clr_en(1'b0), .clr_mask(8'h00),
    .buf_inputs(buf_b), .edge_flags(flg_b), .any_edge(any_b), .sample_tick(tick_b));
  input_conditioner #(.WIDTH(8), .SYNC_STAGES(2), .TICK_DIV(4), .DB_SAMPLES(3), .INVERT_MASK(8'h00)) dut_c (
    .clk(clk), .rst_n(rst_n), .raw_inputs(raw_c), .clr_en(1'b0), .clr_mask(8'h00),
    .buf_inputs(buf_c), .edge_flags(flg_c), .any_edge(any_c), .sample_tick(tick_c));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] probe(input int sel);
    case (sel)
      0: return buf_a;
      1: return flg_a;
      2: return {7'b0, any_a};
      4: return buf_b;
      5: return {7'b0, tick_b};
      6: return buf_c;
      7: return flg_c;
      default: return 8'h00;
    endcase
  endfunction

  // first clock edge at or after 'from' on which the TICK_DIV=4 instances update their counters
  function automatic int first_tick(input int from);
    int e = from;
    while ((e - 1 - rel) % 4 != 0) e++;
    return e;
  endfunction

  task automatic expect_at(input int tag, input int sel, input logic [7:0] v, input string nm);
    sb.push_back('{tag, sel, v, nm});
  endtask

  task automatic check_now(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // monitor: compare every scoreboard entry whose cycle has arrived
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].tag <= cyc) begin
        n_chk++;
        if (probe(sb[i].sel) !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h want %h", sb[i].name, cyc, probe(sb[i].sel), sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    int k, j, e1;
    rst_n = 0; raw_a = 8'h0F; raw_b = 8'h00; raw_c = 8'h00; clr_en = 0; clr_mask = 8'h00;
    repeat (3) @(negedge clk);
    check_now("rst_buf", buf_a, 8'h00);
    check_now("rst_flags", flg_a, 8'h00);
    check_now("rst_tick", {7'b0, tick_a}, 8'h00);
    @(negedge clk);
    rst_n = 1;
    rel = cyc;
    for (int t = 1; t <= 50; t++) begin
      expect_at(rel + t, 0, 8'h00, "pol_buf_quiet");
      expect_at(rel + t, 1, 8'h00, "pol_flags_quiet");
    end
    for (int t = 1; t <= 12; t++) expect_at(rel + t, 5, (t % 4 == 0) ? 8'h01 : 8'h00, "prescale_tick");
    repeat (55) @(negedge clk);
    raw_a = 8'h1F;
    k = cyc;
    expect_at(k + 4, 0, 8'h00, "lat_buf_early");
    expect_at(k + 5, 0, 8'h10, "lat_buf");
    expect_at(k + 5, 1, 8'h10, "lat_flag");
    expect_at(k + 5, 2, 8'h01, "lat_any");
    repeat (8) @(negedge clk);
    raw_a = 8'h3F;
    k = cyc;
    for (int t = 1; t <= 10; t++) begin
      expect_at(k + t, 0, 8'h10, "glitch_buf");
      expect_at(k + t, 1, 8'h10, "glitch_flag");
    end
    repeat (2) @(negedge clk);
    raw_a = 8'h1F;
    repeat (10) @(negedge clk);
    raw_a = 8'h3F;
    k = cyc;
    expect_at(k + 4, 0, 8'h10, "bit5_early");
    expect_at(k + 5, 0, 8'h30, "bit5_buf");
    expect_at(k + 5, 1, 8'h30, "bit5_flag");
    repeat (8) @(negedge clk);
    raw_a = 8'h7F;
    repeat (4) @(negedge clk);
    clr_en = 1; clr_mask = 8'hFF;
    expect_at(cyc + 1, 0, 8'h70, "collide_buf");
    expect_at(cyc + 1, 1, 8'h40, "collide_flag");
    @(negedge clk);
    clr_en = 0; clr_mask = 8'h00;
    expect_at(cyc + 1, 1, 8'h40, "collide_hold");
    repeat (3) @(negedge clk);
    clr_en = 1; clr_mask = 8'h0F;
    expect_at(cyc + 1, 1, 8'h40, "clr_other_bits");
    @(negedge clk);
    clr_en = 0; clr_mask = 8'h40;
    expect_at(cyc + 1, 1, 8'h40, "clr_disabled");
    @(negedge clk);
    clr_en = 1;
    expect_at(cyc + 1, 1, 8'h00, "clr_bit6");
    expect_at(cyc + 1, 2, 8'h00, "clr_any");
    @(negedge clk);
    clr_en = 0; clr_mask = 8'h00;
    raw_a = 8'h6F;
    k = cyc;
    expect_at(k + 4, 0, 8'h70, "fall_early");
    expect_at(k + 5, 0, 8'h60, "fall_buf");
    expect_at(k + 5, 1, 8'h00, "fall_no_flag");
    repeat (8) @(negedge clk);
    raw_b = 8'h01;
    j = cyc;
    e1 = first_tick(j + 3);
    for (int t = j + 1; t <= e1 + 3; t++) expect_at(t, 4, 8'h00, "div4_early");
    expect_at(e1 + 4, 4, 8'h01, "div4_buf");
    repeat (e1 + 6 - j) @(negedge clk);
    raw_c = 8'h01;
    j = cyc;
    for (int t = 1; t <= 24; t++) begin
      expect_at(j + t, 6, 8'h00, "div4_glitch_buf");
      expect_at(j + t, 7, 8'h00, "div4_glitch_flag");
    end
    repeat (7) @(negedge clk);
    raw_c = 8'h00;
    repeat (18) @(negedge clk);
    raw_c = 8'h02;
    j = cyc;
    e1 = first_tick(j + 3);
    expect_at(e1 + 7, 6, 8'h00, "db3_early");
    expect_at(e1 + 8, 6, 8'h02, "db3_buf");
    expect_at(e1 + 8, 7, 8'h02, "db3_flag");
    repeat (e1 + 10 - j) @(negedge clk);
    raw_a = 8'hEF;
    repeat (4) @(negedge clk);
    check_now("pre_reset_buf", buf_a, 8'h60);
    #2 rst_n = 0;
    #1;
    check_now("async_buf", buf_a, 8'h00);
    check_now("async_tick", {7'b0, tick_a}, 8'h00);
    check_now("async_any", {7'b0, any_a}, 8'h00);
    check_now("async_buf_c", buf_c, 8'h00);
    @(negedge clk);
    rst_n = 1;
    k = cyc;
    expect_at(k + 4, 0, 8'h00, "rerun_early");
    expect_at(k + 5, 0, 8'hE0, "rerun_buf");
    expect_at(k + 5, 1, 8'hE0, "rerun_flag");
    expect_at(k + 5, 2, 8'h01, "rerun_any");
    repeat (10) @(negedge clk);
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
